neuron_mac_sequencer: RTL and testbench
=======================================

# neuron_mac_sequencer

Layer sequencer that time-multiplexes one shared multiply-accumulate datapath across all neurons of a fully connected layer. It sits between the top-level control and the `top` datapath (8 inputs, 8 neurons, 32-bit Q12.20). It steps input and weight indices, clears and drains the accumulator, and writes one activated result per neuron into the output vector. A start/busy/done handshake frames each layer pass.

## Interface
Parameters:
- `N_IN`, 8, inputs per neuron (≥2)
- `N_OUT`, 8, neurons per layer (≥1)
- `DW`, 32, data width
- `INT_W`, 12, integer bits; `INT_W + FRAC_W` must equal `DW`
- `FRAC_W`, 20, fractional bits
- `MAC_LAT`, 2, cycles from last `mac_valid` to `acc_in` being final (≥1)

Ports:
- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-low
- `start` in 1: begin layer pass; sampled only in IDLE
- `stall` in 1: datapath/weight memory not ready; honoured only in ISSUE
- `acc_in` in DW: accumulator value from datapath
- `busy` out 1: high in every non-IDLE state
- `done` out 1: one-cycle pulse at end of pass
- `mac_valid` out 1: operand pair valid this cycle
- `mac_clr` out 1: first term of a neuron; datapath loads instead of accumulating
- `x_sel` out clog2(N_IN): input index
- `w_addr` out clog2(N_IN*N_OUT): weight address = n*N_IN + i
- `y_we` out 1: output write strobe
- `y_idx` out clog2(N_OUT): output neuron index
- `y_data` out DW: activated result

## Operation
- Registered state: IDLE, ISSUE, DRAIN, WRITE, DONE. Counters: `i` (input), `n` (neuron), `d` (drain).
- IDLE: all outputs 0. `start`=1 → ISSUE with i=n=0.
- ISSUE: `mac_valid` = !stall; `x_sel`=i; `w_addr`=n*N_IN+i; `mac_clr` = (i==0)&&!stall. When stall=1, i, n and state hold, and `x_sel`/`w_addr` stay stable. When !stall and i==N_IN-1 → DRAIN, d=MAC_LAT-1. Otherwise i++.
- DRAIN: waits MAC_LAT cycles (d counts down to 0), ignores stall → WRITE.
- WRITE: `y_we`=1, `y_idx`=n, `y_data`=act(`acc_in`). If n==N_OUT-1 → DONE, else n++, i=0 → ISSUE.
- DONE: `done`=1, `busy`=1 → IDLE.
- `start` outside IDLE is ignored. It is not queued.
- `mac_valid`/`mac_clr` are combinational from state and `stall`. All other outputs decode registered state and counters only.
- `x_sel`, `w_addr`, `y_idx`, `y_data` are 0 whenever their strobe is low.
- `reset`=0 at any edge → IDLE, counters 0, all outputs 0 from the next cycle. No partial `y_we` may follow.

## Timing
- Cycle 1 is the first ISSUE cycle, one edge after `start` is sampled.
- Without stall, neuron n occupies cycles n*(N_IN+MAC_LAT+1)+1 … +(N_IN+MAC_LAT+1). ISSUE comes first for N_IN cycles, then DRAIN for MAC_LAT cycles, then WRITE for 1 cycle.
- Defaults (11 cycles/neuron): neuron n ISSUE n*11+1..n*11+8, DRAIN n*11+9..n*11+10, WRITE n*11+11. DONE is cycle 89. `busy` is high cycles 1–89. IDLE resumes at cycle 90, and a new `start` may be sampled there.
- Each stalled ISSUE cycle delays all later events by exactly 1 cycle.
- `acc_in` is sampled in the WRITE cycle only.

## Configuration
- `SEQ_RELU_EN` defined: act(x) = 0 if x[DW-1]=1, else x (ReLU on Q12.20).
- `SEQ_RELU_EN` not defined: act(x) = x (identity). The activation stage is downstream.

## Test plan
- Reset: hold `reset`=0 for 2 cycles, then release with `start`=0 → every output stays 0 and `busy`=0 indefinitely.
- Nominal pass: pulse `start`, no stall, `acc_in`=0x0010_0000*(n+1) during neuron n's WRITE → `w_addr` walks 0..63. `mac_clr` is high at cycles 1,12,…,78. `y_we` fires at cycles 11,22,…,88 with `y_idx` 0..7 and `y_data` 0x0010_0000..0x0080_0000. `done` pulses at cycle 89.
- Stall: hold `stall`=1 for cycles 28–30 (neuron 2, i=5) → `mac_valid`=0 there, `x_sel`=5 and `w_addr`=21 held, remaining events shift +3, and `done` lands at cycle 92.
- Activation: `acc_in`=0xFFF0_0000 at a WRITE → `y_data`=0 with `SEQ_RELU_EN`, 0xFFF0_0000 without.
- Protocol abuse: pulse `start` at cycle 20 → ignored and `done` still at 89. Drive `reset`=0 at cycle 40 → IDLE from cycle 41 with no further `y_we`. A later `start` runs a full 89-cycle pass.

Source files
------------

// File: rtl/neuron_mac_sequencer_if.sv
// neuron_mac_sequencer_if
//   Bundles the layer handshake (start/busy/done), the MAC operand stream
//   (stall, mac_valid, mac_clr, x_sel, w_addr), the accumulator return
//   (acc_in) and the output-vector write port (y_we, y_idx, y_data).
//   master: sequencer side (drives strobes, indices and results).
//   slave : control/datapath side (drives start, stall, acc_in).
//   Parameters must match those of the sequencer it connects to.
interface neuron_mac_sequencer_if #(
    parameter int N_IN  = 8,
    parameter int N_OUT = 8,
    parameter int DW    = 32
);
    localparam int XW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int AW = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1;
    localparam int YW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    logic          start;
    logic          stall;
    logic [DW-1:0] acc_in;
    logic          busy;
    logic          done;
    logic          mac_valid;
    logic          mac_clr;
    logic [XW-1:0] x_sel;
    logic [AW-1:0] w_addr;
    logic          y_we;
    logic [YW-1:0] y_idx;
    logic [DW-1:0] y_data;

    modport master (
        input  start, stall, acc_in,
        output busy, done, mac_valid, mac_clr, x_sel, w_addr,
               y_we, y_idx, y_data
    );

    modport slave (
        output start, stall, acc_in,
        input  busy, done, mac_valid, mac_clr, x_sel, w_addr,
               y_we, y_idx, y_data
    );
endinterface

// File: rtl/neuron_mac_sequencer.sv
// neuron_mac_sequencer
//   Time-multiplexes one shared MAC datapath over all neurons of a fully
//   connected layer: issues N_IN operand pairs per neuron, waits MAC_LAT
//   cycles for the accumulator to settle, then writes the activated result.
//   Ports:
//     clk    - rising-edge clock
//     reset  - synchronous, active-low
//     bus    - neuron_mac_sequencer_if.master (start/stall/acc_in in;
//              busy/done/mac_valid/mac_clr/x_sel/w_addr/y_we/y_idx/y_data out)
//   Build option:
//     SEQ_RELU_EN - when defined, y_data = ReLU(acc_in); otherwise identity.
module neuron_mac_sequencer #(
    parameter int N_IN    = 8,
    parameter int N_OUT   = 8,
    parameter int DW      = 32,
    parameter int INT_W   = 12,
    parameter int FRAC_W  = 20,
    parameter int MAC_LAT = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    neuron_mac_sequencer_if.master       bus
);
    localparam int IW  = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int NW  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int AW  = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1;
    localparam int DLW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    localparam logic [IW-1:0]  I_LAST = IW'(N_IN - 1);
    localparam logic [NW-1:0]  N_LAST = NW'(N_OUT - 1);
    localparam logic [DLW-1:0] D_INIT = DLW'(MAC_LAT - 1);

    if (INT_W + FRAC_W != DW) begin : g_bad_fmt
        $error("neuron_mac_sequencer: INT_W + FRAC_W must equal DW");
    end

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        WRITE,
        DONE
    } state_t;

    state_t         state;
    logic [IW-1:0]  i;
    logic [NW-1:0]  n;
    logic [DLW-1:0] d;
    // Running weight address; equals n*N_IN + i during ISSUE, so the
    // product never has to be formed.
    logic [AW-1:0]  wa;
    logic [DW-1:0]  act_val;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            i          <= '0;
            n          <= '0;
            d          <= '0;
            wa         <= '0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.y_we   <= 1'b0;
            bus.y_idx  <= '0;
            bus.x_sel  <= '0;
            bus.w_addr <= '0;
        end else begin
            // Strobed outputs default low / zero; each branch sets the
            // values that belong to the state being entered.
            bus.done   <= 1'b0;
            bus.y_we   <= 1'b0;
            bus.y_idx  <= '0;
            bus.x_sel  <= '0;
            bus.w_addr <= '0;

            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        state    <= ISSUE;
                        i        <= '0;
                        n        <= '0;
                        wa       <= '0;
                        bus.busy <= 1'b1;
                    end
                end

                ISSUE: begin
                    if (bus.stall) begin
                        bus.x_sel  <= i;
                        bus.w_addr <= wa;
                    end else if (i == I_LAST) begin
                        state <= DRAIN;
                        d     <= D_INIT;
                        wa    <= wa + 1'b1;
                    end else begin
                        i          <= i + 1'b1;
                        wa         <= wa + 1'b1;
                        bus.x_sel  <= i + 1'b1;
                        bus.w_addr <= wa + 1'b1;
                    end
                end

                DRAIN: begin
                    if (d == '0) begin
                        state     <= WRITE;
                        bus.y_we  <= 1'b1;
                        bus.y_idx <= n;
                    end else begin
                        d <= d - 1'b1;
                    end
                end

                WRITE: begin
                    if (n == N_LAST) begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                    end else begin
                        state      <= ISSUE;
                        n          <= n + 1'b1;
                        i          <= '0;
                        bus.w_addr <= wa;
                    end
                end

                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end

                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

    // Operand strobes react to stall in the same cycle.
    assign bus.mac_valid = (state == ISSUE) && !bus.stall;
    assign bus.mac_clr   = (state == ISSUE) && (i == '0) && !bus.stall;

`ifdef SEQ_RELU_EN
    assign act_val = bus.acc_in[DW-1] ? '0 : bus.acc_in;
`else
    assign act_val = bus.acc_in;
`endif

    // acc_in only reaches the output while the write strobe is up.
    assign bus.y_data = bus.y_we ? act_val : '0;

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// tb_neuron_mac_sequencer
//   Directed bench for neuron_mac_sequencer with default parameters
//   (8 inputs, 8 neurons, 32-bit, MAC_LAT=2 -> 11 cycles per neuron).
//   Honours SEQ_RELU_EN for the expected activation result.
module tb_neuron_mac_sequencer;
    logic clk;
    logic reset;

    neuron_mac_sequencer_if #(.N_IN(8), .N_OUT(8), .DW(32)) bus ();

    neuron_mac_sequencer #(
        .N_IN(8), .N_OUT(8), .DW(32), .INT_W(12), .FRAC_W(20), .MAC_LAT(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks     = 0;
    int failures   = 0;
    int t          = 0;   // position on the unstalled timeline, 0 = idle
    int cyc_no     = 0;   // cycle number, 1 = first ISSUE cycle
    int done_at    = -1;
    int we_cnt     = 0;
    int neg_neuron = -1;  // neuron whose accumulator is driven negative
    logic [31:0] y_neg;

`ifdef SEQ_RELU_EN
    localparam logic [31:0] EXP_NEG = 32'h0000_0000;
`else
    localparam logic [31:0] EXP_NEG = 32'hFFF0_0000;
`endif

    function automatic logic [31:0] act(input logic [31:0] x);
`ifdef SEQ_RELU_EN
        return x[31] ? 32'h0 : x;
`else
        return x;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs, compare every output against the
    // timeline expectation, then advance the timeline.
    task automatic step(input logic st, input logic stl, input logic rs);
        int nn, p;
        logic ev, ec, eb, ed, ewe;
        logic [31:0] ex, ea, ey, eyd, acc;
        nn = 0; p = 0;
        ev = 0; ec = 0; eb = 0; ed = 0; ewe = 0;
        ex = 0; ea = 0; ey = 0; eyd = 0; acc = 0;
        if (t >= 1 && t <= 88) begin
            nn  = (t - 1) / 11;
            p   = (t - 1) % 11;
            acc = (nn == neg_neuron) ? 32'hFFF0_0000 : 32'(32'h0010_0000 * (nn + 1));
        end
        @(posedge clk);
        #1;
        cyc_no++;
        bus.start  = st;
        bus.stall  = stl;
        bus.acc_in = acc;
        reset      = rs;
        #1;
        if (t >= 1 && t <= 88) begin
            eb = 1;
            if (p < 8) begin
                ev = !stl;
                ec = (p == 0) && !stl;
                ex = 32'(p);
                ea = 32'(nn * 8 + p);
            end else if (p == 10) begin
                ewe = 1;
                ey  = 32'(nn);
                eyd = act(acc);
            end
        end else if (t == 89) begin
            eb = 1;
            ed = 1;
        end
        chk("busy",      32'(bus.busy),      32'(eb));
        chk("done",      32'(bus.done),      32'(ed));
        chk("mac_valid", 32'(bus.mac_valid), 32'(ev));
        chk("mac_clr",   32'(bus.mac_clr),   32'(ec));
        chk("x_sel",     32'(bus.x_sel),     ex);
        chk("w_addr",    32'(bus.w_addr),    ea);
        chk("y_we",      32'(bus.y_we),      32'(ewe));
        chk("y_idx",     32'(bus.y_idx),     ey);
        chk("y_data",    bus.y_data,         eyd);
        if (bus.done === 1'b1) done_at = cyc_no;
        if (bus.y_we === 1'b1) begin
            we_cnt++;
            if (neg_neuron >= 0 && 32'(bus.y_idx) == 32'(neg_neuron)) y_neg = bus.y_data;
        end
        if (!rs)                          t = 0;
        else if (t == 0) begin
            if (st) begin t = 1; cyc_no = 0; end
        end
        else if (t <= 88 && p < 8 && stl) t = t;
        else if (t == 89)                 t = 0;
        else                              t++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b0;
        bus.start  = 1'b0;
        bus.stall  = 1'b0;
        bus.acc_in = '0;
        y_neg      = '0;

        // Reset held for two edges, then released with start low.
        repeat (2) @(posedge clk);
        repeat (6) step(1'b0, 1'b0, 1'b1);

        // Nominal pass.
        done_at = -1; we_cnt = 0;
        step(1'b1, 1'b0, 1'b1);
        for (int c = 1; c <= 89; c++) step(1'b0, 1'b0, 1'b1);
        chk("nominal_done_cycle", 32'(done_at), 32'd89);
        chk("nominal_writes",     32'(we_cnt),  32'd8);
        repeat (3) step(1'b0, 1'b0, 1'b1);

        // Stall cycles 28..30 (neuron 2, i=5) plus a negative accumulator
        // on neuron 3.
        done_at = -1; we_cnt = 0; neg_neuron = 3;
        step(1'b1, 1'b0, 1'b1);
        for (int c = 1; c <= 92; c++) step(1'b0, (c >= 28 && c <= 30), 1'b1);
        chk("stall_done_cycle", 32'(done_at), 32'd92);
        chk("stall_writes",     32'(we_cnt),  32'd8);
        chk("act_negative",     y_neg,        EXP_NEG);
        neg_neuron = -1;
        repeat (3) step(1'b0, 1'b0, 1'b1);

        // start re-asserted mid-pass is ignored.
        done_at = -1; we_cnt = 0;
        step(1'b1, 1'b0, 1'b1);
        for (int c = 1; c <= 89; c++) step((c == 20), 1'b0, 1'b1);
        chk("restart_ignored_done", 32'(done_at), 32'd89);
        chk("restart_ignored_wr",   32'(we_cnt),  32'd8);
        step(1'b0, 1'b0, 1'b1);

        // Reset during cycle 40 aborts the pass.
        done_at = -1; we_cnt = 0;
        step(1'b1, 1'b0, 1'b1);
        for (int c = 1; c <= 40; c++) step(1'b0, 1'b0, (c != 40));
        for (int c = 41; c <= 55; c++) step(1'b0, 1'b0, 1'b1);
        chk("abort_writes", 32'(we_cnt),  32'd3);
        chk("abort_done",   32'(done_at), 32'hFFFF_FFFF);

        // Full pass after the abort.
        done_at = -1; we_cnt = 0;
        step(1'b1, 1'b0, 1'b1);
        for (int c = 1; c <= 89; c++) step(1'b0, 1'b0, 1'b1);
        chk("post_abort_done",   32'(done_at), 32'd89);
        chk("post_abort_writes", 32'(we_cnt),  32'd8);
        repeat (3) step(1'b0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
